sprite_compositor: RTL and testbench

- Parametrised multi-sprite renderer between the VGA timing generator and the RGB output pins.
- Draws NUM_SPRITES 1-bit sprites over a 1-bit background with fixed priority.
- Generates the per-sprite sprite-ROM addresses and scrolls obstacle sprites left once per frame with wrap-around.
- Reports sprite-0-versus-obstacle pixel collisions once per frame, for the game FSM.

---
 rtl/sprite_compositor_pkg.sv | 27 ++
 rtl/sprite_compositor_channel.sv | 87 ++++++++
 rtl/sprite_compositor.sv | 140 ++++++++++++++
 tb/tb_sprite_compositor.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared constants and types for the sprite compositor and its channels.
package sprite_compositor_pkg;

    // Pixel coordinate widths from the VGA timing generator (640x480 visible).
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    // Per-channel sprite dimension width (1..127) and scroll-speed width.
    localparam int DIM_W   = 7;
    localparam int SPEED_W = 4;

    // Reload column for a scrolled sprite that has left the screen.
    localparam int DEFAULT_WRAP_X = 740;

    // Colour constants: opaque pixels are black, empty pixels are white.
    localparam logic [11:0] DEFAULT_FG = 12'h000;
    localparam logic [11:0] DEFAULT_BG = 12'hfff;

    // Which source decides the colour of a stage-2 pixel.
    typedef enum logic [1:0] {
        SEL_BLANK,
        SEL_EMPTY,
        SEL_SPRITE,
        SEL_BGRAM
    } pix_sel_e;

endpackage

// File: rtl/sprite_compositor_channel.sv
// One sprite channel: position register with scroll/wrap, in-box test
// against the current pixel, and the row-major sprite ROM address counter.
module sprite_compositor_channel
    import sprite_compositor_pkg::*;
#(
    parameter int COORD_W = 11,
    parameter int ADDR_W  = 13,
    parameter int WRAP_X  = DEFAULT_WRAP_X
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_en,
    input  logic                      frame_end,
    input  logic [X_W-1:0]            x,
    input  logic [Y_W-1:0]            y,
    input  logic                      load,
    input  logic signed [COORD_W-1:0] x_in,
    input  logic signed [COORD_W-1:0] y_in,
    input  logic [DIM_W-1:0]          w,
    input  logic [DIM_W-1:0]          h,
    input  logic                      en,
    input  logic                      scroll,
    input  logic [SPEED_W-1:0]        scroll_speed,
    output logic                      in_box,
    output logic [ADDR_W-1:0]         addr
);

    // One extra bit so that sx+w and x-speed never overflow for negative positions.
    localparam int CW = COORD_W + 1;

    logic signed [COORD_W-1:0] pos_x_q, pos_x_d;
    logic signed [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;

    logic signed [CW-1:0] sx, sy, px, py, wx, hy, spd, moved, neg_w;

    assign sx    = {{(CW-COORD_W){pos_x_q[COORD_W-1]}}, pos_x_q};
    assign sy    = {{(CW-COORD_W){pos_y_q[COORD_W-1]}}, pos_y_q};
    assign px    = {{(CW-X_W){1'b0}}, x};
    assign py    = {{(CW-Y_W){1'b0}}, y};
    assign wx    = {{(CW-DIM_W){1'b0}}, w};
    assign hy    = {{(CW-DIM_W){1'b0}}, h};
    assign spd   = {{(CW-SPEED_W){1'b0}}, scroll_speed};
    assign moved = sx - spd;
    assign neg_w = -wx;

    assign in_box = en && (sx <= px) && (px < sx + wx) && (sy <= py) && (py < sy + hy);
    assign addr   = cnt_q;

    // Next position (load beats scroll) and next address count, all gated by pix_en.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        cnt_d   = cnt_q;
        if (pix_en) begin
            if (load) begin
                pos_x_d = x_in;
                pos_y_d = y_in;
            end else if (frame_end && scroll) begin
                if (moved < neg_w) begin
                    pos_x_d = COORD_W'(WRAP_X);
                end else begin
                    pos_x_d = moved[COORD_W-1:0];
                end
            end
            if (frame_end) begin
                cnt_d = '0;
            end else if (in_box && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state registers; sprites park off-screen at the wrap column after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_x_q <= COORD_W'(WRAP_X);
            pos_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: per-channel sprite logic, two-stage pixel
// pipeline, fixed-priority colour selection and per-frame collision flag.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int                 NUM_SPRITES = 4,
    parameter int                 COORD_W     = 11,
    parameter int                 ADDR_W      = 13,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] FG_COLOR    = COLOR_W'(DEFAULT_FG),
    parameter logic [COLOR_W-1:0] BG_COLOR    = COLOR_W'(DEFAULT_BG),
    parameter int                 WRAP_X      = DEFAULT_WRAP_X
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pix_en,
    input  logic                              frame_end,
    input  logic                              active,
    input  logic [X_W-1:0]                    x,
    input  logic [Y_W-1:0]                    y,
    input  logic [NUM_SPRITES-1:0]            spr_load,
    input  logic [NUM_SPRITES*COORD_W-1:0]    spr_x_in,
    input  logic [NUM_SPRITES*COORD_W-1:0]    spr_y_in,
    input  logic [NUM_SPRITES*DIM_W-1:0]      spr_w,
    input  logic [NUM_SPRITES*DIM_W-1:0]      spr_h,
    input  logic [NUM_SPRITES-1:0]            spr_en,
    input  logic [NUM_SPRITES-1:0]            spr_scroll,
    input  logic [SPEED_W-1:0]                scroll_speed,
    output logic [NUM_SPRITES*ADDR_W-1:0]     rom_addr,
    input  logic [NUM_SPRITES-1:0]            rom_data,
    input  logic                              bg_data,
    output logic [COLOR_W-1:0]                rgb,
    output logic                              active_out,
    output logic                              collision
);

    logic [NUM_SPRITES-1:0] in_box;
    logic [NUM_SPRITES-1:0] in_box_q, in_box_d;
    logic                   active_q, active_d;
    logic [COLOR_W-1:0]     rgb_q, rgb_d;
    logic                   active_out_q, active_out_d;
    logic                   hit_acc_q, hit_acc_d;
    logic                   collision_q, collision_d;

    logic [NUM_SPRITES-1:0] opaque;
    logic                   hit;
    pix_sel_e               sel;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_chan
        sprite_compositor_channel #(
            .COORD_W (COORD_W),
            .ADDR_W  (ADDR_W),
            .WRAP_X  (WRAP_X)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .pix_en       (pix_en),
            .frame_end    (frame_end),
            .x            (x),
            .y            (y),
            .load         (spr_load[i]),
            .x_in         (spr_x_in[i*COORD_W +: COORD_W]),
            .y_in         (spr_y_in[i*COORD_W +: COORD_W]),
            .w            (spr_w[i*DIM_W +: DIM_W]),
            .h            (spr_h[i*DIM_W +: DIM_W]),
            .en           (spr_en[i]),
            .scroll       (spr_scroll[i]),
            .scroll_speed (scroll_speed),
            .in_box       (in_box[i]),
            .addr         (rom_addr[i*ADDR_W +: ADDR_W])
        );
    end

    // The player (channel 0) colliding with any obstacle channel on the same pixel.
    assign opaque = in_box_q & rom_data;
    assign hit    = opaque[0] & (|opaque[NUM_SPRITES-1:1]);

    assign rgb        = rgb_q;
    assign active_out = active_out_q;
    assign collision  = collision_q;

    // Pick the colour source: blanking, any opaque sprite, background bit, else empty.
    always_comb begin
        sel = SEL_EMPTY;
        if (!active_q) begin
            sel = SEL_BLANK;
        end else if (|opaque) begin
            sel = SEL_SPRITE;
        end else if (bg_data) begin
            sel = SEL_BGRAM;
        end
    end

    // Pipeline and collision next-state; nothing moves unless pix_en is high.
    always_comb begin
        in_box_d     = in_box_q;
        active_d     = active_q;
        rgb_d        = rgb_q;
        active_out_d = active_out_q;
        hit_acc_d    = hit_acc_q;
        collision_d  = collision_q;
        if (pix_en) begin
            in_box_d     = in_box;
            active_d     = active;
            active_out_d = active_q;
            case (sel)
                SEL_SPRITE: rgb_d = FG_COLOR;
                SEL_BGRAM:  rgb_d = FG_COLOR;
                SEL_EMPTY:  rgb_d = BG_COLOR;
                default:    rgb_d = '0;
            endcase
            if (frame_end) begin
                collision_d = hit_acc_q | hit;
                hit_acc_d   = 1'b0;
            end else if (hit) begin
                hit_acc_d   = 1'b1;
            end
        end
    end

    // Pipeline, output and collision registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_box_q     <= '0;
            active_q     <= 1'b0;
            rgb_q        <= '0;
            active_out_q <= 1'b0;
            hit_acc_q    <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            in_box_q     <= in_box_d;
            active_q     <= active_d;
            rgb_q        <= rgb_d;
            active_out_q <= active_out_d;
            hit_acc_q    <= hit_acc_d;
            collision_q  <= collision_d;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed testbench for sprite_compositor: table of single-pixel vectors
// plus hand-written frame scans for scrolling, clipping, collision and reset.
`timescale 1ns/1ps
module tb_sprite_compositor;

    localparam int N      = 4;
    localparam int CW     = 11;
    localparam int AW     = 13;
    localparam int DW     = 7;
    localparam int IDLE_X = 1023;
    localparam int IDLE_Y = 511;
    localparam logic [11:0] FG = 12'h000;
    localparam logic [11:0] BG = 12'hfff;

    logic            clk;
    logic            reset;
    logic            pix_en;
    logic            frame_end;
    logic            active;
    logic [9:0]      x;
    logic [8:0]      y;
    logic [N-1:0]    spr_load;
    logic [N*CW-1:0] spr_x_in;
    logic [N*CW-1:0] spr_y_in;
    logic [N*DW-1:0] spr_w;
    logic [N*DW-1:0] spr_h;
    logic [N-1:0]    spr_en;
    logic [N-1:0]    spr_scroll;
    logic [3:0]      scroll_speed;
    logic [N*AW-1:0] rom_addr;
    logic [N-1:0]    rom_data;
    logic            bg_data;
    logic [11:0]     rgb;
    logic            active_out;
    logic            collision;

    int n_checks = 0;
    int n_fail   = 0;

    int mx [N];
    int my [N];
    int mw [N];
    int mh [N];
    bit men [N];

    int            exp_cnt   [N];
    int            first_col [N];
    logic [AW-1:0] prev_addr [N];
    int fg_cnt, pix_err, addr_err, coll_err;
    int prev_x, prev_y;
    bit prev_valid, prev_act;

    typedef struct {
        int          vx;
        int          vy;
        bit          vact;
        bit          vrom;
        bit          vbg;
        logic [11:0] exp_rgb;
        bit          exp_act;
    } vec_t;
    vec_t vecs [10];

    sprite_compositor #(
        .NUM_SPRITES (N),
        .COORD_W     (CW),
        .ADDR_W      (AW),
        .COLOR_W     (12),
        .FG_COLOR    (FG),
        .BG_COLOR    (BG),
        .WRAP_X      (740)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_en       (pix_en),
        .frame_end    (frame_end),
        .active       (active),
        .x            (x),
        .y            (y),
        .spr_load     (spr_load),
        .spr_x_in     (spr_x_in),
        .spr_y_in     (spr_y_in),
        .spr_w        (spr_w),
        .spr_h        (spr_h),
        .spr_en       (spr_en),
        .spr_scroll   (spr_scroll),
        .scroll_speed (scroll_speed),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .bg_data      (bg_data),
        .rgb          (rgb),
        .active_out   (active_out),
        .collision    (collision)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: actual timeout, expected end of test");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic bit in_box_m(input int i, input int px, input int py);
        return men[i] && (px >= mx[i]) && (px < mx[i] + mw[i]) &&
               (py >= my[i]) && (py < my[i] + mh[i]);
    endfunction

    function automatic bit any_box_m(input int px, input int py);
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r |= in_box_m(i, px, py);
        return r;
    endfunction

    function automatic int addr_of(input int i);
        logic [AW-1:0] a;
        a = rom_addr[i*AW +: AW];
        return int'(a);
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        x = 10'(IDLE_X); y = 9'(IDLE_Y); active = 1'b0;
        pix_en = 1'b1; frame_end = 1'b1;
        step();
        frame_end = 1'b0;
    endtask

    task automatic set_sprite(input int i, input int sx, input int sy, input int w,
                              input int h, input bit en, input bit scr);
        spr_x_in[i*CW +: CW] = CW'(sx);
        spr_y_in[i*CW +: CW] = CW'(sy);
        spr_w[i*DW +: DW]    = DW'(w);
        spr_h[i*DW +: DW]    = DW'(h);
        spr_en[i]            = en;
        spr_scroll[i]        = scr;
        spr_load             = '0;
        spr_load[i]          = 1'b1;
        x = 10'(IDLE_X); y = 9'(IDLE_Y); active = 1'b0;
        pix_en = 1'b1; frame_end = 1'b0;
        step();
        spr_load = '0;
        mx[i] = sx; my[i] = sy; mw[i] = w; mh[i] = h; men[i] = en;
    endtask

    // Present one pixel; compare the previous pixel's colour and every address counter.
    task automatic scan_pixel(input int xx, input int yy, input bit act, input bit exp_coll);
        logic [11:0] exp_rgb;
        x = 10'(xx); y = 9'(yy); active = act;
        pix_en = 1'b1; frame_end = 1'b0;
        for (int i = 0; i < N; i++) if (in_box_m(i, xx, yy)) exp_cnt[i]++;
        step();
        for (int i = 0; i < N; i++) begin
            if (addr_of(i) != exp_cnt[i]) addr_err++;
            if ((rom_addr[i*AW +: AW] != prev_addr[i]) && (first_col[i] < 0)) first_col[i] = xx;
            prev_addr[i] = rom_addr[i*AW +: AW];
        end
        if (prev_valid) begin
            exp_rgb = !prev_act ? 12'h000 : (any_box_m(prev_x, prev_y) ? FG : BG);
            if ((rgb !== exp_rgb) || (active_out !== prev_act)) pix_err++;
            if (prev_act && (rgb === FG)) fg_cnt++;
        end
        if (collision !== exp_coll) coll_err++;
        prev_valid = 1'b1; prev_x = xx; prev_y = yy; prev_act = act;
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1, input bit exp_coll);
        fg_cnt = 0; pix_err = 0; addr_err = 0; coll_err = 0; prev_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_cnt[i]   = 0;
            first_col[i] = -1;
            prev_addr[i] = rom_addr[i*AW +: AW];
        end
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                scan_pixel(xx, yy, 1'b1, exp_coll);
        scan_pixel(IDLE_X, IDLE_Y, 1'b0, exp_coll);
        scan_pixel(IDLE_X, IDLE_Y, 1'b0, exp_coll);
    endtask

    task automatic check_scan(input string name);
        check_output({name, "_pixels"}, pix_err, 0);
        check_output({name, "_addr"}, addr_err, 0);
        check_output({name, "_coll"}, coll_err, 0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        x = 10'(v.vx); y = 9'(v.vy); active = v.vact;
        pix_en = 1'b1; frame_end = 1'b0;
        step();
        x = 10'(IDLE_X); y = 9'(IDLE_Y); active = 1'b0;
        rom_data[0] = v.vrom;
        bg_data = v.vbg;
        step();
    endtask

    initial begin
        reset = 1'b0; pix_en = 1'b0; frame_end = 1'b0; active = 1'b0;
        x = '0; y = '0; spr_load = '0; spr_x_in = '0; spr_y_in = '0;
        spr_w = {N{7'd1}}; spr_h = {N{7'd1}}; spr_en = '0; spr_scroll = '0;
        scroll_speed = 4'd3; rom_data = '1; bg_data = 1'b0;
        for (int i = 0; i < N; i++) begin
            mx[i] = 740; my[i] = 0; mw[i] = 1; mh[i] = 1; men[i] = 1'b0;
        end

        vecs[0] = '{100,  50, 1'b1, 1'b1, 1'b0, FG,     1'b1};
        vecs[1] = '{159, 109, 1'b1, 1'b1, 1'b0, FG,     1'b1};
        vecs[2] = '{160,  50, 1'b1, 1'b1, 1'b0, BG,     1'b1};
        vecs[3] = '{100, 110, 1'b1, 1'b1, 1'b0, BG,     1'b1};
        vecs[4] = '{ 99,  50, 1'b1, 1'b1, 1'b0, BG,     1'b1};
        vecs[5] = '{100,  49, 1'b1, 1'b1, 1'b0, BG,     1'b1};
        vecs[6] = '{130,  80, 1'b1, 1'b0, 1'b0, BG,     1'b1};
        vecs[7] = '{130,  80, 1'b1, 1'b0, 1'b1, FG,     1'b1};
        vecs[8] = '{ 10,  10, 1'b1, 1'b1, 1'b1, FG,     1'b1};
        vecs[9] = '{130,  80, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};

        #22;
        check_output("reset_rgb", int'(rgb), 0);
        check_output("reset_active_out", int'(active_out), 0);
        check_output("reset_collision", int'(collision), 0);
        check_output("reset_rom_addr", (rom_addr == '0) ? 0 : 1, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single-pixel vectors around the edges of a 60x60 sprite at (100,50).
        set_sprite(0, 100, 50, 60, 60, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(vecs[k]);
            check_output($sformatf("vec%0d_rgb", k), int'(rgb), int'(vecs[k].exp_rgb));
            check_output($sformatf("vec%0d_active", k), int'(active_out), int'(vecs[k].exp_act));
        end
        rom_data = '1; bg_data = 1'b0;

        // Full sprite-0 frame: 3600 opaque pixels, addresses 0..3599.
        frame_pulse();
        scan(90, 169, 40, 119, 1'b0);
        check_scan("frame60");
        check_output("frame60_fg_count", fg_cnt, 3600);
        check_output("frame60_addr_end", addr_of(0), 3600);
        check_output("frame60_first_col", first_col[0], 100);

        // pix_en low freezes everything, even with frame_end and an in-box pixel.
        x = 10'd130; y = 9'd80; active = 1'b1; frame_end = 1'b1; pix_en = 1'b0;
        repeat (3) step();
        check_output("hold_addr", addr_of(0), 3600);
        check_output("hold_active_out", int'(active_out), 0);
        frame_end = 1'b0;
        frame_pulse();
        check_output("frame_end_clears_addr", addr_of(0), 0);

        // Scrolling sprite 1 (w=48) from x=12 at 3 px/frame, down to -48 then wrap.
        set_sprite(0, 100, 50, 60, 60, 1'b0, 1'b0);
        set_sprite(1, 12, 300, 48, 1, 1'b1, 1'b1);
        frame_pulse();
        mx[1] = 9;
        scan(0, 799, 300, 300, 1'b0);
        check_scan("scroll9");
        check_output("scroll9_first", first_col[1], 9);
        check_output("scroll9_count", addr_of(1), 48);
        repeat (18) frame_pulse();
        mx[1] = -45;
        scan(0, 799, 300, 300, 1'b0);
        check_scan("scroll_m45");
        check_output("scroll_m45_first", first_col[1], 0);
        check_output("scroll_m45_count", addr_of(1), 3);
        frame_pulse();
        mx[1] = -48;
        scan(0, 799, 300, 300, 1'b0);
        check_output("scroll_m48_first", first_col[1], -1);
        check_output("scroll_m48_count", addr_of(1), 0);
        frame_pulse();
        mx[1] = 740;
        scan(0, 799, 300, 300, 1'b0);
        check_scan("wrap740");
        check_output("wrap740_first", first_col[1], 740);
        check_output("wrap740_count", addr_of(1), 48);
        frame_pulse();
        mx[1] = 737;
        scan(0, 799, 300, 300, 1'b0);
        check_output("wrap737_first", first_col[1], 737);

        // Load and frame_end on the same strobe: the load wins, no decrement.
        spr_x_in[1*CW +: CW] = CW'(300);
        spr_load[1] = 1'b1;
        x = 10'(IDLE_X); y = 9'(IDLE_Y); active = 1'b0; pix_en = 1'b1; frame_end = 1'b1;
        step();
        spr_load = '0; frame_end = 1'b0;
        mx[1] = 300;
        scan(0, 799, 300, 300, 1'b0);
        check_scan("load_wins");
        check_output("load_wins_first", first_col[1], 300);
        check_output("load_wins_count", addr_of(1), 48);
        set_sprite(1, 300, 300, 48, 1, 1'b0, 1'b0);

        // Sprite clipped at the left edge: x=-10, w=49 leaves columns 0..38.
        set_sprite(2, -10, 20, 49, 3, 1'b1, 1'b0);
        frame_pulse();
        scan(0, 99, 18, 24, 1'b0);
        check_scan("clip");
        check_output("clip_fg_count", fg_cnt, 117);
        check_output("clip_addr", addr_of(2), 117);
        check_output("clip_first", first_col[2], 0);
        set_sprite(2, -10, 20, 49, 3, 1'b0, 1'b0);

        // One-pixel overlap at (11,11) in frame K; flag held in K+1, cleared after.
        set_sprite(0, 10, 10, 2, 2, 1'b1, 1'b0);
        set_sprite(1, 11, 11, 2, 2, 1'b1, 1'b0);
        frame_pulse();
        scan(5, 20, 5, 20, 1'b0);
        check_scan("overlap_k");
        check_output("overlap_k_fg", fg_cnt, 7);
        frame_pulse();
        check_output("collision_set", int'(collision), 1);
        set_sprite(1, 30, 30, 2, 2, 1'b1, 1'b0);
        scan(5, 40, 5, 40, 1'b1);
        check_scan("frame_k1");
        check_output("frame_k1_fg", fg_cnt, 8);
        frame_pulse();
        check_output("collision_cleared", int'(collision), 0);

        // Mid-frame reset clears outputs at once; next frame renders normally.
        set_sprite(1, 11, 11, 2, 2, 1'b1, 1'b0);
        frame_pulse();
        scan(5, 20, 5, 20, 1'b0);
        frame_pulse();
        check_output("pre_reset_collision", int'(collision), 1);
        active = 1'b1; pix_en = 1'b1;
        x = 10'd10; y = 9'd10; step();
        x = 10'd11; y = 9'd10; step();
        x = 10'd50; y = 9'd50; step();
        step();
        check_output("pre_reset_rgb", int'(rgb), int'(BG));
        check_output("pre_reset_addr", addr_of(0), 2);
        #3;
        reset = 1'b0;
        #1;
        check_output("async_rgb", int'(rgb), 0);
        check_output("async_collision", int'(collision), 0);
        check_output("async_active_out", int'(active_out), 0);
        check_output("async_rom_addr", (rom_addr == '0) ? 0 : 1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            mx[i] = 740; my[i] = 0;
        end
        set_sprite(0, 10, 10, 2, 2, 1'b1, 1'b0);
        set_sprite(1, 11, 11, 2, 2, 1'b1, 1'b0);
        frame_pulse();
        scan(5, 20, 5, 20, 1'b0);
        check_scan("post_reset");
        check_output("post_reset_fg", fg_cnt, 7);
        frame_pulse();
        check_output("post_reset_collision", int'(collision), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
